// File: rtl/arf_pkg.sv
// Shared definitions for the multi-ported architectural register file.
// Holds default parameter values, the dump FSM state encoding and a
// small address-qualification helper.
package arf_pkg;

  localparam int AR_SIZE_DEF  = 6;
  localparam int AR_ARRAY_DEF = 64;
  localparam int DATA_W_DEF   = 32;
  localparam int NUM_RD_DEF   = 4;
  localparam int NUM_WR_DEF   = 2;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    DUMP = 2'd1,
    DONE = 2'd2
  } dump_state_e;

  // A write lands (and is counted) only for nonzero, in-range addresses.
  function automatic logic addr_writable(input int addr, input int ar_array);
    return (addr != 0) && (addr < ar_array);
  endfunction

endpackage

// File: rtl/arf_dump_ctrl.sv
// Dump sequencer: walks addresses 0..AR_ARRAY-1 with a valid/ready
// handshake, then pulses done for one cycle before returning to IDLE.
// The data for each beat is looked up by the parent from the live array.
module arf_dump_ctrl
  import arf_pkg::*;
#(
  parameter int AR_SIZE  = AR_SIZE_DEF,
  parameter int AR_ARRAY = AR_ARRAY_DEF
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               dump_start,
  input  logic               dump_ready,
  output logic               dump_valid,
  output logic [AR_SIZE-1:0] dump_addr,
  output logic               dump_busy,
  output logic               dump_done
);

  localparam logic [AR_SIZE-1:0] LAST_ADDR = AR_SIZE'(AR_ARRAY - 1);

  dump_state_e        state_reg, state_next;
  logic [AR_SIZE-1:0] addr_reg, addr_next;

  // State and beat-address registers; reset aborts any dump in progress.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_reg <= IDLE;
      addr_reg  <= '0;
    end else begin
      state_reg <= state_next;
      addr_reg  <= addr_next;
    end
  end

  // Next-state and handshake outputs; dump_start is only honoured in IDLE.
  always_comb begin
    state_next = state_reg;
    addr_next  = addr_reg;
    dump_valid = 1'b0;
    dump_busy  = 1'b0;
    dump_done  = 1'b0;
    case (state_reg)
      IDLE: begin
        if (dump_start) begin
          state_next = DUMP;
          addr_next  = '0;
        end
      end
      DUMP: begin
        dump_valid = 1'b1;
        dump_busy  = 1'b1;
        if (dump_ready) begin
          if (addr_reg == LAST_ADDR) begin
            state_next = DONE;
          end else begin
            addr_next = addr_reg + AR_SIZE'(1);
          end
        end
      end
      DONE: begin
        dump_busy  = 1'b1;
        dump_done  = 1'b1;
        state_next = IDLE;
      end
      default: state_next = IDLE;
    endcase
  end

  assign dump_addr = addr_reg;

endmodule

// File: rtl/arf_mp.sv
// Multi-ported architectural register file: NUM_RD registered read ports,
// NUM_WR retire write ports (highest index wins on collision), a retire
// counter and a full-file dump port driven by arf_dump_ctrl.
// Build option: define ARF_BYPASS_EN to forward same-cycle writes to reads.
module arf_mp
  import arf_pkg::*;
#(
  parameter int AR_SIZE  = AR_SIZE_DEF,
  parameter int AR_ARRAY = AR_ARRAY_DEF,
  parameter int DATA_W   = DATA_W_DEF,
  parameter int NUM_RD   = NUM_RD_DEF,
  parameter int NUM_WR   = NUM_WR_DEF
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic                       rd_en,
  input  logic [NUM_RD*AR_SIZE-1:0]  rd_addr,
  output logic [NUM_RD*DATA_W-1:0]   rd_data,
  output logic                       rd_valid,
  input  logic [NUM_WR-1:0]          wr_en,
  input  logic [NUM_WR*AR_SIZE-1:0]  wr_addr,
  input  logic [NUM_WR*DATA_W-1:0]   wr_data,
  input  logic                       dump_start,
  input  logic                       dump_ready,
  output logic                       dump_valid,
  output logic [AR_SIZE-1:0]         dump_addr,
  output logic [DATA_W-1:0]          dump_data,
  output logic                       dump_busy,
  output logic                       dump_done,
  output logic [31:0]                retire_cnt
);

  // Register storage is flop based because reset must clear every entry.
  logic [DATA_W-1:0]  regs_reg    [AR_ARRAY];
  logic [AR_SIZE-1:0] rd_addr_a   [NUM_RD];
  logic [DATA_W-1:0]  rd_val      [NUM_RD];
  logic [DATA_W-1:0]  rd_data_reg [NUM_RD];
  logic               rd_valid_reg;
  logic [AR_SIZE-1:0] wr_addr_a   [NUM_WR];
  logic [DATA_W-1:0]  wr_data_a   [NUM_WR];
  logic [NUM_WR-1:0]  wr_ok;
  logic [31:0]        retire_cnt_reg;
  logic [31:0]        retire_inc;
  logic [DATA_W-1:0]  dump_data_mux;

  genvar gi;

  // Unpack write ports and qualify them (enabled, nonzero, in range).
  generate
    for (gi = 0; gi < NUM_WR; gi++) begin : g_wr
      assign wr_addr_a[gi] = wr_addr[gi*AR_SIZE +: AR_SIZE];
      assign wr_data_a[gi] = wr_data[gi*DATA_W +: DATA_W];
      assign wr_ok[gi]     = wr_en[gi] && addr_writable(int'(wr_addr_a[gi]), AR_ARRAY);
    end
  endgenerate

  // Unpack read addresses and pack registered read data.
  generate
    for (gi = 0; gi < NUM_RD; gi++) begin : g_rd
      assign rd_addr_a[gi]                 = rd_addr[gi*AR_SIZE +: AR_SIZE];
      assign rd_data[gi*DATA_W +: DATA_W]  = rd_data_reg[gi];
    end
  endgenerate

  // Array write: ports scanned in ascending order so the highest index wins.
  // Entry 0 is never written and stays at its reset value of zero.
  always_ff @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < AR_ARRAY; i++) begin
        regs_reg[i] <= '0;
      end
    end else begin
      for (int i = 1; i < AR_ARRAY; i++) begin
        for (int p = 0; p < NUM_WR; p++) begin
          if (wr_ok[p] && (wr_addr_a[p] == AR_SIZE'(i))) begin
            regs_reg[i] <= wr_data_a[p];
          end
        end
      end
    end
  end

  // Read mux per port; unmatched (out-of-range) addresses and entry 0 give 0.
  always_comb begin
    for (int k = 0; k < NUM_RD; k++) begin
      rd_val[k] = '0;
      for (int i = 1; i < AR_ARRAY; i++) begin
        if (rd_addr_a[k] == AR_SIZE'(i)) begin
          rd_val[k] = regs_reg[i];
        end
      end
`ifdef ARF_BYPASS_EN
      for (int p = 0; p < NUM_WR; p++) begin
        if (wr_ok[p] && (wr_addr_a[p] == rd_addr_a[k])) begin
          rd_val[k] = wr_data_a[p];
        end
      end
`endif
    end
  end

  // Read output registers: capture on rd_en, otherwise hold.
  always_ff @(posedge clk) begin
    if (rst) begin
      rd_valid_reg <= 1'b0;
      for (int k = 0; k < NUM_RD; k++) begin
        rd_data_reg[k] <= '0;
      end
    end else begin
      rd_valid_reg <= rd_en;
      if (rd_en) begin
        for (int k = 0; k < NUM_RD; k++) begin
          rd_data_reg[k] <= rd_val[k];
        end
      end
    end
  end

  // Number of qualified writes this cycle; colliding ports each count.
  always_comb begin
    retire_inc = '0;
    for (int p = 0; p < NUM_WR; p++) begin
      retire_inc = retire_inc + 32'(wr_ok[p]);
    end
  end

  // Retire counter, wraps naturally at 2**32.
  always_ff @(posedge clk) begin
    if (rst) begin
      retire_cnt_reg <= '0;
    end else begin
      retire_cnt_reg <= retire_cnt_reg + retire_inc;
    end
  end

  // Dump data looks at live array content so mid-dump writes are seen.
  always_comb begin
    dump_data_mux = '0;
    for (int i = 0; i < AR_ARRAY; i++) begin
      if (dump_addr == AR_SIZE'(i)) begin
        dump_data_mux = regs_reg[i];
      end
    end
  end

  arf_dump_ctrl #(
    .AR_SIZE  (AR_SIZE),
    .AR_ARRAY (AR_ARRAY)
  ) u_dump_ctrl (
    .clk        (clk),
    .rst        (rst),
    .dump_start (dump_start),
    .dump_ready (dump_ready),
    .dump_valid (dump_valid),
    .dump_addr  (dump_addr),
    .dump_busy  (dump_busy),
    .dump_done  (dump_done)
  );

  assign rd_valid   = rd_valid_reg;
  assign retire_cnt = retire_cnt_reg;
  assign dump_data  = dump_data_mux;

endmodule

// File: tb/tb_arf_mp.sv
// Directed bench for arf_mp: a reference array model predicts read data,
// which is queued at issue and compared when the registered result appears.
module tb_arf_mp;

  localparam int AS = 6;
  localparam int AA = 64;
  localparam int DW = 32;
  localparam int NR = 4;
  localparam int NW = 2;

  logic             clk = 1'b0;
  logic             rst;
  logic             rd_en;
  logic [NR*AS-1:0] rd_addr;
  logic [NR*DW-1:0] rd_data;
  logic             rd_valid;
  logic [NW-1:0]    wr_en;
  logic [NW*AS-1:0] wr_addr;
  logic [NW*DW-1:0] wr_data;
  logic             dump_start;
  logic             dump_ready;
  logic             dump_valid;
  logic [AS-1:0]    dump_addr;
  logic [DW-1:0]    dump_data;
  logic             dump_busy;
  logic             dump_done;
  logic [31:0]      retire_cnt;

  int checks = 0;
  int errors = 0;

  logic [DW-1:0] mdl     [AA];
  logic [DW-1:0] last_rd [NR];
  logic [31:0]   cnt_m;
  logic [DW-1:0] exp_q   [$];

  arf_mp #(
    .AR_SIZE(AS), .AR_ARRAY(AA), .DATA_W(DW), .NUM_RD(NR), .NUM_WR(NW)
  ) dut (
    .clk        (clk),
    .rst        (rst),
    .rd_en      (rd_en),
    .rd_addr    (rd_addr),
    .rd_data    (rd_data),
    .rd_valid   (rd_valid),
    .wr_en      (wr_en),
    .wr_addr    (wr_addr),
    .wr_data    (wr_data),
    .dump_start (dump_start),
    .dump_ready (dump_ready),
    .dump_valid (dump_valid),
    .dump_addr  (dump_addr),
    .dump_data  (dump_data),
    .dump_busy  (dump_busy),
    .dump_done  (dump_done),
    .retire_cnt (retire_cnt)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic wr(input int p, input int a, input logic [DW-1:0] d);
    wr_en[p]            = 1'b1;
    wr_addr[p*AS +: AS] = AS'(a);
    wr_data[p*DW +: DW] = d;
  endtask

  task automatic rd(input int k, input int a);
    rd_en               = 1'b1;
    rd_addr[k*AS +: AS] = AS'(a);
  endtask

  // One clock: predict reads from the model, clock, update model, compare.
  task automatic tick();
    logic          issued;
    logic [DW-1:0] e;
    int            ra;
    int            wa;
    issued = rd_en && !rst;
    if (issued) begin
      for (int k = 0; k < NR; k++) begin
        ra = int'(rd_addr[k*AS +: AS]);
        e  = (ra < AA) ? mdl[ra] : '0;
`ifdef ARF_BYPASS_EN
        for (int p = 0; p < NW; p++) begin
          wa = int'(wr_addr[p*AS +: AS]);
          if (wr_en[p] && wa == ra && wa != 0 && wa < AA) e = wr_data[p*DW +: DW];
        end
`endif
        exp_q.push_back(e);
      end
    end
    @(posedge clk);
    #1;
    if (rst) begin
      for (int i = 0; i < AA; i++) mdl[i] = '0;
      for (int k = 0; k < NR; k++) last_rd[k] = '0;
      cnt_m = '0;
      exp_q.delete();
    end else begin
      for (int p = 0; p < NW; p++) begin
        wa = int'(wr_addr[p*AS +: AS]);
        if (wr_en[p] && wa != 0 && wa < AA) begin
          mdl[wa] = wr_data[p*DW +: DW];
          cnt_m   = cnt_m + 32'd1;
        end
      end
    end
    wr_en      = '0;
    rd_en      = 1'b0;
    dump_start = 1'b0;
    check("rd_valid", rd_valid, issued);
    for (int k = 0; k < NR; k++) begin
      if (issued) last_rd[k] = exp_q.pop_front();
      check($sformatf("rd_data%0d", k), rd_data[k*DW +: DW], last_rd[k]);
    end
    check("retire_cnt", retire_cnt, cnt_m);
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog timeout");
    $fatal(1, "watchdog");
  end

  initial begin
    int beat;
    int cyc;
    rst        = 1'b1;
    rd_en      = 1'b0;
    rd_addr    = '0;
    wr_en      = '0;
    wr_addr    = '0;
    wr_data    = '0;
    dump_start = 1'b0;
    dump_ready = 1'b0;
    cnt_m      = '0;
    for (int i = 0; i < AA; i++) mdl[i] = '0;
    for (int k = 0; k < NR; k++) last_rd[k] = '0;

    // Traffic presented during reset must be dropped.
    wr(0, 3, 32'hDEAD_BEEF);
    rd(0, 3);
    tick();
    tick();
    rst = 1'b0;
    check("rst_dump_valid", dump_valid, 1'b0);
    check("rst_dump_busy", dump_busy, 1'b0);
    check("rst_dump_done", dump_done, 1'b0);
    rd(0, 3);
    tick();

    // Write then read next cycle.
    wr(0, 5, 32'h1234);
    tick();
    rd(0, 5);
    tick();
    wr(1, 9, 32'h11);
    tick();

    // Collision: port 1 wins, both ports counted.
    wr(0, 7, 32'hA);
    wr(1, 7, 32'hB);
    tick();
    rd(0, 7); rd(1, 5); rd(2, 9); rd(3, 0);
    tick();

    // Register 0 ignores writes and is not counted.
    wr(0, 0, 32'hFFFF);
    tick();
    rd(3, 0);
    tick();

    // Same-cycle write/read of p9; then the committed value.
    wr(0, 9, 32'h55);
    rd(1, 9);
    tick();
    rd(1, 9);
    tick();

    // Same-cycle collision with a read of the colliding address.
    wr(0, 12, 32'h1);
    wr(1, 12, 32'h2);
    rd(0, 12);
    tick();

    // Idle cycles: rd_data must hold.
    tick();
    tick();

    // Random mixed traffic.
    for (int n = 0; n < 40; n++) begin
      for (int p = 0; p < NW; p++) begin
        if ($urandom_range(1, 0) == 1) wr(p, int'($urandom_range(AA - 1, 0)), $urandom);
      end
      if ($urandom_range(1, 0) == 1) begin
        for (int k = 0; k < NR; k++) rd(k, int'($urandom_range(AA - 1, 0)));
      end
      tick();
    end

    // Full dump with ready toggling, a write ahead of the cursor, and a
    // dump_start retrigger that must be ignored.
    dump_start = 1'b1;
    tick();
    beat = 0;
    cyc  = 0;
    while (beat < AA && cyc < 600) begin
      dump_ready = ((cyc % 2) == 1);
      if (cyc == 5) wr(1, 40, 32'hCAFE_0040);
      if (cyc == 7) dump_start = 1'b1;
      check("dump_valid", dump_valid, 1'b1);
      if (dump_valid && dump_ready) begin
        check("dump_addr", dump_addr, beat);
        check("dump_data", dump_data, mdl[beat]);
        beat++;
      end
      tick();
      cyc++;
    end
    dump_ready = 1'b0;
    check("dump_beats", beat, AA);
    check("done_pulse", dump_done, 1'b1);
    check("done_busy", dump_busy, 1'b1);
    check("done_valid", dump_valid, 1'b0);
    tick();
    check("done_clear", dump_done, 1'b0);
    check("idle_busy", dump_busy, 1'b0);

    // Reset during the dump at beat 10.
    dump_start = 1'b1;
    tick();
    dump_ready = 1'b1;
    beat = 0;
    cyc  = 0;
    while (beat < 10 && cyc < 100) begin
      if (dump_valid) begin
        check("dump2_addr", dump_addr, beat);
        beat++;
      end
      tick();
      cyc++;
    end
    check("dump2_beat10", dump_addr, 10);
    rst = 1'b1;
    tick();
    rst = 1'b0;
    dump_ready = 1'b0;
    check("mid_rst_valid", dump_valid, 1'b0);
    check("mid_rst_busy", dump_busy, 1'b0);
    check("mid_rst_done", dump_done, 1'b0);
    for (int a = 0; a < AA; a += NR) begin
      for (int k = 0; k < NR; k++) rd(k, a + k);
      tick();
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/arf_mp.md
ARF_MP -- requirements
Module: arf_mp

Interface
REQ-001 SHALL have parameter AR_SIZE, default 6, register address width.
REQ-002 SHALL have parameter AR_ARRAY, default 64, number of registers (at most 2**AR_SIZE).
REQ-003 SHALL have parameter DATA_W, default 32, register data width.
REQ-004 SHALL have parameter NUM_RD, default 4, number of read ports.
REQ-005 SHALL have parameter NUM_WR, default 2, number of retire write ports.
REQ-006 SHALL have port clk, input, 1, the single clock; all logic on its rising edge.
REQ-007 SHALL have port rst, input, 1, reset: synchronous, active-high.
REQ-008 SHALL have port rd_en, input, 1, read request for all read ports.
REQ-009 SHALL have port rd_addr, input, NUM_RD*AR_SIZE, packed read addresses (port k in slice k).
REQ-010 SHALL have port rd_data, output, NUM_RD*DATA_W, packed registered read data.
REQ-011 SHALL have port rd_valid, output, 1, rd_data holds the result of last cycle's rd_en.
REQ-012 SHALL have port wr_en, input, NUM_WR, per-port retire write enable.
REQ-013 SHALL have port wr_addr, input, NUM_WR*AR_SIZE, packed write addresses.
REQ-014 SHALL have port wr_data, input, NUM_WR*DATA_W, packed write data.
REQ-015 SHALL have port dump_start, input, 1, pulse that starts a full-file dump.
REQ-016 SHALL have port dump_ready, input, 1, consumer accepts a dump beat.
REQ-017 SHALL have ports dump_valid (output, 1), dump_addr (output, AR_SIZE) and dump_data (output, DATA_W): the dump beat.
REQ-018 SHALL have ports dump_busy (output, 1) and dump_done (output, 1, one-cycle pulse after last beat).
REQ-019 SHALL have port retire_cnt, output, 32, count of committed nonzero-address writes.

Function
REQ-020 Register 0 SHALL always read 0; writes to address 0 are discarded and not counted.
REQ-021 Reads SHALL have 1-cycle latency: rd_en at cycle t -> rd_data/rd_valid at t+1; rd_data holds its value while rd_en is low.
REQ-022 On same-address write collision, the highest-index write port SHALL win.
REQ-023 Writes SHALL be visible in the array at t+1; a read in cycle t of an address written in cycle t SHALL return the new data only when ARF_BYPASS_EN is defined.
REQ-024 Addresses >= AR_ARRAY SHALL read 0 and be ignored on write.
REQ-025 retire_cnt SHALL add popcount of enabled, nonzero, in-range write ports per cycle (collisions count each port) and wrap modulo 2**32.
REQ-026 Dump FSM states: IDLE -> (dump_start) -> DUMP -> (last beat accepted) -> DONE -> IDLE; dump_start outside IDLE is ignored.
REQ-027 In DUMP, dump_valid SHALL be high and dump_addr/dump_data stable until dump_valid&&dump_ready; addresses run 0..AR_ARRAY-1 in order.
REQ-028 dump_data SHALL reflect the current array content, including writes committed during the dump.
REQ-029 dump_busy SHALL be high in DUMP and DONE; dump_done SHALL be high only in DONE, for exactly one cycle.

Reset
REQ-030 rst SHALL clear all registers, rd_data, rd_valid, retire_cnt, dump_valid, dump_busy and dump_done to 0 and force the FSM to IDLE, including mid-dump.
REQ-031 Writes and reads presented in a cycle with rst high SHALL be dropped.

Configuration
REQ-032 Macro ARF_BYPASS_EN defined: write-to-read forwarding per REQ-023, newest (highest-index) port forwarded; undefined: reads in cycle t return pre-write array content.

Structure
REQ-033 Default parameter values and the dump FSM state encoding (IDLE, DUMP, DONE) SHALL live in shared package arf_pkg.
REQ-034 The dump FSM SHALL be sub-module arf_dump_ctrl; the array, ports and counter stay in arf_mp.

Verification
REQ-035 Write p5=0x1234 on port 0, read p5 next cycle -> rd_data slice 0 = 0x1234, rd_valid=1.
REQ-036 Same cycle port0 p7=0xA, port1 p7=0xB -> p7 reads 0xB; retire_cnt +2.
REQ-037 Write p0=0xFFFF -> p0 reads 0; retire_cnt unchanged.
REQ-038 Write p9=0x55 and read p9 same cycle -> 0x55 with ARF_BYPASS_EN, prior value without.
REQ-039 dump_start with dump_ready toggling every other cycle -> 64 beats, addr 0..63 in order, dump_done one-cycle pulse after beat 63.
REQ-040 rst asserted at dump beat 10 -> next cycle FSM IDLE, dump_valid=0, all registers read 0, retire_cnt=0.
